control_multi: RTL and testbench

//  Multicycle LEGv8 control FSM. Sequences the shared datapath: one memory port, one ALU, PC, IR, A/B/ALUOut regs.
//  Per instruction: FETCH -> DECODE -> class states. Drives mux selects and write enables from its state.

---
 rtl/control_multi.sv | 239 +++++++++++++++++++++++
 tb/tb_control_multi.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/control_multi.sv
`default_nettype none
// ============================================================================
// Module      : control_multi
// Description : Multicycle LEGv8 control FSM with memory handshake and fault trap
// Revision    : 1.0
// ============================================================================
module control_multi #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iOPCODE,
    input  logic        iMemReady,
    output logic        oPCWrite,
    output logic        oPCWriteCond,
    output logic        oBranchNot,
    output logic        oIorD,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic        oIRWrite,
    output logic        oReg2Loc,
    output logic [1:0]  oOrigAULA,
    output logic [1:0]  oOrigBULA,
    output logic [1:0]  oALUop,
    output logic [1:0]  oOrigPC,
    output logic        oMemToReg,
    output logic        oRegWrite,
    output logic        oFault,
    output logic [3:0]  oState
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_FAULT    = 4'd15
    } state_t;

    // Opcode classes (11-bit IR[31:21] fields)
    localparam logic [10:0] OPC_ADD   = 11'b10001011000;
    localparam logic [10:0] OPC_SUB   = 11'b11001011000;
    localparam logic [10:0] OPC_AND   = 11'b10001010000;
    localparam logic [10:0] OPC_ORR   = 11'b10101010000;
    localparam logic [10:0] OPC_EOR   = 11'b11001010000;
    localparam logic [10:0] OPC_LSL   = 11'b11010011011;
    localparam logic [10:0] OPC_LSR   = 11'b11010011010;
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OPC_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OPC_EORI  = 10'b1101001000;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_LDURB = 11'b00111000010;
    localparam logic [10:0] OPC_LDURH = 11'b01111000010;
    localparam logic [10:0] OPC_LDURW = 11'b10111000100;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [10:0] OPC_STURB = 11'b00111000000;
    localparam logic [10:0] OPC_STURH = 11'b01111000000;
    localparam logic [10:0] OPC_STURW = 11'b10111000000;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [5:0]  OPC_B     = 6'b000101;

    localparam logic             TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] LAST_WAIT  = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             fault;

    logic is_r, is_i, is_load, is_store, is_cb, is_cbnz, is_b;
    logic mem_wait, timeout;

    always_comb begin
        is_r     = iOPCODE inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_EOR, OPC_LSL, OPC_LSR};
        is_i     = iOPCODE[10:1] inside {OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORRI, OPC_EORI};
        is_load  = iOPCODE inside {OPC_LDUR, OPC_LDURB, OPC_LDURH, OPC_LDURW};
        is_store = iOPCODE inside {OPC_STUR, OPC_STURB, OPC_STURH, OPC_STURW};
        is_cbnz  = (iOPCODE[10:3] == OPC_CBNZ);
        is_cb    = (iOPCODE[10:3] == OPC_CBZ) || is_cbnz;
        is_b     = (iOPCODE[10:5] == OPC_B);
    end

    assign mem_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // A ready in the final allowed cycle still completes the access
    assign timeout  = TIMEOUT_EN && mem_wait && !iMemReady && (wait_cnt == LAST_WAIT);

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (iMemReady)    next_state = S_DECODE;
                else if (timeout) next_state = S_FAULT;
            end
            S_DECODE: begin
                if (is_r)                      next_state = S_EXEC_R;
                else if (is_i)                 next_state = S_EXEC_I;
                else if (is_load || is_store)  next_state = S_MEM_ADDR;
                else if (is_cb)                next_state = S_BRANCH;
                else if (is_b)                 next_state = S_JUMP;
                else                           next_state = S_FAULT;
            end
            S_EXEC_R:   next_state = S_ALU_WB;
            S_EXEC_I:   next_state = S_ALU_WB;
            S_ALU_WB:   next_state = S_FETCH;
            S_MEM_ADDR: next_state = is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (iMemReady)    next_state = S_MEM_WB;
                else if (timeout) next_state = S_FAULT;
            end
            S_MEM_WB:   next_state = S_FETCH;
            S_MEM_WR: begin
                if (iMemReady)    next_state = S_FETCH;
                else if (timeout) next_state = S_FAULT;
            end
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            default:    next_state = S_FAULT;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_FAULT)
                fault <= 1'b1;
            if (next_state != state || iMemReady || !mem_wait)
                wait_cnt <= '0;
            else if (wait_cnt != {CNT_W{1'b1}})
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    logic       pc_write, pc_write_cond, branch_not, iord, mem_read, mem_write;
    logic       ir_write, reg2loc, mem_to_reg, reg_write;
    logic [1:0] orig_a, orig_b, alu_op, orig_pc;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_not    = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg2loc       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        orig_a        = 2'b00;
        orig_b        = 2'b00;
        alu_op        = 2'b00;
        orig_pc       = 2'b00;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                orig_b   = 2'b01;
                ir_write = iMemReady;
                pc_write = iMemReady;
            end
            S_DECODE: begin
                orig_b  = 2'b11;
                reg2loc = is_store || is_cb;
            end
            S_EXEC_R: begin
                orig_a = 2'b01;
                alu_op = 2'b10;
            end
            S_EXEC_I: begin
                orig_a = 2'b01;
                orig_b = 2'b10;
                alu_op = 2'b10;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_MEM_ADDR: begin
                orig_a = 2'b01;
                orig_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                reg2loc   = 1'b1;
            end
            S_BRANCH: begin
                orig_a        = 2'b01;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                orig_pc       = 2'b01;
                branch_not    = is_cbnz;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                orig_pc  = 2'b10;
            end
            default: ;
        endcase
    end

    // Reset blanks every output immediately so an in-flight access never commits
    assign oPCWrite     = !iRST && pc_write;
    assign oPCWriteCond = !iRST && pc_write_cond;
    assign oBranchNot   = !iRST && branch_not;
    assign oIorD        = !iRST && iord;
    assign oMemRead     = !iRST && mem_read;
    assign oMemWrite    = !iRST && mem_write;
    assign oIRWrite     = !iRST && ir_write;
    assign oReg2Loc     = !iRST && reg2loc;
    assign oMemToReg    = !iRST && mem_to_reg;
    assign oRegWrite    = !iRST && reg_write;
    assign oFault       = !iRST && fault;
    assign oOrigAULA    = iRST ? 2'b00 : orig_a;
    assign oOrigBULA    = iRST ? 2'b00 : orig_b;
    assign oALUop       = iRST ? 2'b00 : alu_op;
    assign oOrigPC      = iRST ? 2'b00 : orig_pc;
    assign oState       = iRST ? 4'd0  : state;

endmodule
`default_nettype wire

// File: tb/tb_control_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_multi
// Description : Scoreboard bench for control_multi (MEM_TIMEOUT = 4)
// Revision    : 1.0
// ============================================================================
module tb_control_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] opcode = '0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, branch_not, iord, mem_read, mem_write;
    logic        ir_write, reg2loc, mem_to_reg, reg_write, fault;
    logic [1:0]  orig_a, orig_b, alu_op, orig_pc;
    logic [3:0]  state;

    always #5 clk = ~clk;

    control_multi #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .iCLK(clk), .iRST(rst), .iOPCODE(opcode), .iMemReady(mem_ready),
        .oPCWrite(pc_write), .oPCWriteCond(pc_write_cond), .oBranchNot(branch_not),
        .oIorD(iord), .oMemRead(mem_read), .oMemWrite(mem_write), .oIRWrite(ir_write),
        .oReg2Loc(reg2loc), .oOrigAULA(orig_a), .oOrigBULA(orig_b), .oALUop(alu_op),
        .oOrigPC(orig_pc), .oMemToReg(mem_to_reg), .oRegWrite(reg_write),
        .oFault(fault), .oState(state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] cur_op   = '0;
    logic [22:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected control word for one cycle, straight from the per-state output table
    function automatic logic [22:0] exp_vec(input logic [3:0] st, input logic rdy, input logic r);
        logic pcw, pcwc, bn, io, mr, mw, irw, r2l, m2r, rw, flt;
        logic [1:0] a, b, alu, opc;
        logic [7:0] top8;
        logic is_st, is_cb, is_cbnz;
        pcw = 0; pcwc = 0; bn = 0; io = 0; mr = 0; mw = 0; irw = 0; r2l = 0;
        m2r = 0; rw = 0; flt = 0; a = 0; b = 0; alu = 0; opc = 0;
        top8    = cur_op[10:3];
        is_st   = (cur_op == 11'b11111000000);
        is_cbnz = (top8 == 8'b10110101);
        is_cb   = is_cbnz || (top8 == 8'b10110100);
        case (st)
            4'd0:  begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  begin b = 2'b11; r2l = is_st || is_cb; end
            4'd2:  begin a = 2'b01; alu = 2'b10; end
            4'd3:  begin a = 2'b01; b = 2'b10; alu = 2'b10; end
            4'd4:  rw = 1;
            4'd5:  begin a = 2'b01; b = 2'b10; end
            4'd6:  begin mr = 1; io = 1; end
            4'd7:  begin rw = 1; m2r = 1; end
            4'd8:  begin mw = 1; io = 1; r2l = 1; end
            4'd9:  begin a = 2'b01; alu = 2'b01; pcwc = 1; opc = 2'b01; bn = is_cbnz; end
            4'd10: begin pcw = 1; opc = 2'b10; end
            4'd15: flt = 1;
            default: ;
        endcase
        if (r) return '0;
        return {st, pcw, pcwc, bn, io, mr, mw, irw, r2l, a, b, alu, opc, m2r, rw, flt};
    endfunction

    // One clock: drive inputs after the edge, queue expectation, compare at negedge
    task automatic step(input logic [3:0] st, input logic rdy, input logic r);
        logic [22:0] got, exp;
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        opcode    = cur_op;
        sb.push_back(exp_vec(st, rdy, r));
        @(negedge clk);
        got = {state, pc_write, pc_write_cond, branch_not, iord, mem_read, mem_write,
               ir_write, reg2loc, orig_a, orig_b, alu_op, orig_pc, mem_to_reg, reg_write, fault};
        exp = sb.pop_front();
        check("state", {28'd0, got[22:19]}, {28'd0, exp[22:19]});
        check("outputs", {9'd0, got}, {9'd0, exp});
    endtask

    initial begin
        // Reset with ready high: nothing may fire
        step(4'd0, 1'b1, 1'b1);
        step(4'd0, 1'b1, 1'b1);

        cur_op = 11'b10001011000;             // ADD
        step(0, 1, 0); step(1, 1, 0); step(2, 1, 0); step(4, 1, 0);

        cur_op = 11'b10010001000;             // ADDI
        step(0, 1, 0); step(1, 1, 0); step(3, 1, 0); step(4, 1, 0);

        cur_op = 11'b11111000010;             // LDUR, 3 wait cycles (ready on last allowed cycle)
        step(0, 1, 0); step(1, 1, 0); step(5, 1, 0);
        step(6, 0, 0); step(6, 0, 0); step(6, 0, 0); step(6, 1, 0);
        step(7, 1, 0);

        cur_op = 11'b11111000000;             // STUR, one wait cycle in MEM_WR
        step(0, 1, 0); step(1, 1, 0); step(5, 1, 0); step(8, 0, 0); step(8, 1, 0);

        cur_op = 11'b10110101000;             // CBNZ
        step(0, 1, 0); step(1, 1, 0); step(9, 1, 0);

        cur_op = 11'b10110100111;             // CBZ
        step(0, 1, 0); step(1, 1, 0); step(9, 1, 0);

        cur_op = 11'b00010100000;             // B, after two fetch waits
        step(0, 0, 0); step(0, 0, 0); step(0, 1, 0); step(1, 1, 0); step(10, 1, 0);

        cur_op = 11'b00000000000;             // illegal opcode -> sticky fault, then reset
        step(0, 1, 0); step(1, 1, 0); step(15, 1, 0); step(15, 1, 0); step(15, 1, 1);

        cur_op = 11'b10001011000;             // fetch timeout after 4 cycles
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(15, 1, 0); step(15, 1, 0); step(15, 0, 1);

        cur_op = 11'b11111000010;             // load timeout in MEM_RD
        step(0, 1, 0); step(1, 1, 0); step(5, 1, 0);
        step(6, 0, 0); step(6, 0, 0); step(6, 0, 0); step(6, 0, 0);
        step(15, 1, 0); step(15, 1, 1);

        cur_op = 11'b11111000000;             // reset during MEM_WR abandons the store
        step(0, 1, 0); step(1, 1, 0); step(5, 1, 0); step(8, 1, 1);
        step(0, 1, 0); step(1, 1, 0); step(5, 1, 0); step(8, 1, 0);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
